// File: rtl/term_pkg.sv
// Shared constants for the terminal character arbiter: special characters and
// the arbiter state encoding (chosen so the state doubles as the owner code).
package term_pkg;

  localparam logic [6:0] CHAR_NEWLINE   = 7'h0A;
  localparam logic [6:0] CHAR_BACKSPACE = 7'h08;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_LOCK0 = 2'b01;
  localparam logic [1:0] ST_LOCK1 = 2'b10;

  function automatic logic [1:0] lock_state(input logic req_id);
    return req_id ? ST_LOCK1 : ST_LOCK0;
  endfunction

endpackage

// File: rtl/term_char_fifo.sv
// Character FIFO: synchronous write, combinational head read, extra pointer bit
// distinguishes full from empty.
module term_char_fifo #(
  parameter int DEPTH = 16,
  parameter int BITS  = 4,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [BITS:0]    o_count
);

  logic [BITS:0]    r_wr_ptr;
  logic [BITS:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_full    = (o_count == (BITS+1)'(DEPTH));
  assign o_empty   = (o_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr[BITS-1:0]];

  // NOTE: storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[BITS-1:0]] <= i_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/term_char_arbiter.sv
// Two-requester terminal input arbiter: a line lock keeps one requester's line
// atomic, accepted characters queue in a FIFO and drain as paced add_char strobes.
module term_char_arbiter
  import term_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_BITS    = 4,
  parameter int LOCK_TIMEOUT = 255,
  parameter int LOCK_BITS    = 8,
  parameter int GAP_CYCLES   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [6:0]           req0_char,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [6:0]           req1_char,
  output logic                 req1_ready,
  output logic                 add_char,
  output logic [6:0]           char_value,
  output logic [1:0]           owner,
  output logic [FIFO_BITS:0]   fifo_count
);

  localparam int GAP_BITS = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  logic [1:0]           r_state;
  logic                 r_last_grant;
  logic [LOCK_BITS-1:0] r_lock_cnt;
  logic [GAP_BITS-1:0]  r_gap_cnt;
  logic                 r_add_char;
  logic [6:0]           r_char_value;

  logic                 w_grant0;
  logic                 w_grant1;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [6:0]           w_fifo_head;
  logic                 w_xfer0;
  logic                 w_xfer1;
  logic                 w_xfer;
  logic [6:0]           w_xfer_char;
  logic                 w_pop;

  // NOTE: every output of this block gets a default first, so no latch forms.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    case (r_state)
      ST_LOCK0: w_grant0 = 1'b1;
      ST_LOCK1: w_grant1 = 1'b1;
      default: begin
        if (req0_valid && req1_valid) begin
          w_grant0 = r_last_grant;
          w_grant1 = !r_last_grant;
        end else begin
          w_grant0 = req0_valid;
          w_grant1 = req1_valid;
        end
      end
    endcase
  end

  assign req0_ready  = w_grant0 && !w_fifo_full && !reset;
  assign req1_ready  = w_grant1 && !w_fifo_full && !reset;
  assign w_xfer0     = req0_valid && req0_ready;
  assign w_xfer1     = req1_valid && req1_ready;
  assign w_xfer      = w_xfer0 || w_xfer1;
  assign w_xfer_char = w_xfer1 ? req1_char : req0_char;
  assign w_pop       = !w_fifo_empty && (r_gap_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_lock_cnt   <= '0;
    end else if (w_xfer) begin
      r_last_grant <= w_xfer1;
      r_lock_cnt   <= '0;
      r_state      <= (w_xfer_char == CHAR_NEWLINE) ? ST_IDLE : lock_state(w_xfer1);
    end else if (r_state != ST_IDLE) begin
      // A stalled lock counts too, so a requester cannot hold the line forever.
      if (r_lock_cnt == LOCK_BITS'(LOCK_TIMEOUT - 1)) begin
        r_state    <= ST_IDLE;
        r_lock_cnt <= '0;
      end else begin
        r_lock_cnt <= r_lock_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_add_char   <= 1'b0;
      r_char_value <= '0;
      r_gap_cnt    <= '0;
    end else begin
      r_add_char <= w_pop;
      if (w_pop) begin
        r_char_value <= w_fifo_head;
        r_gap_cnt    <= GAP_BITS'(GAP_CYCLES);
      end else if (r_gap_cnt != '0) begin
        r_gap_cnt <= r_gap_cnt - 1'b1;
      end
    end
  end

  term_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .BITS  (FIFO_BITS),
    .WIDTH (7)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_xfer),
    .i_wdata (w_xfer_char),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (fifo_count)
  );

  assign add_char   = r_add_char;
  assign char_value = r_char_value;
  assign owner      = r_state;

endmodule

// File: doc/term_char_arbiter.md
TERM_CHAR_ARBITER -- requirements
Module: term_char_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 16: output character FIFO entries (power of two).
REQ-002 Parameter FIFO_BITS, default 4: log2(FIFO_DEPTH).
REQ-003 Parameter LOCK_TIMEOUT, default 255: idle cycles after which a line lock is released.
REQ-004 Parameter LOCK_BITS, default 8: width of the lock timeout counter.
REQ-005 Parameter GAP_CYCLES, default 0: idle cycles enforced between consecutive add_char pulses.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 req0_valid  input  1  requester 0 offers a character.
REQ-009 req0_char  input  7  requester 0 ASCII character.
REQ-010 req0_ready  output  1  requester 0 character accepted this cycle when valid.
REQ-011 req1_valid, req1_char, req1_ready: same as REQ-008..010 for requester 1.
REQ-012 add_char  output  1  one-cycle strobe to terminal input.
REQ-013 char_value  output  7  character qualified by add_char.
REQ-014 owner  output  2  2'b00 no lock, 2'b01 locked to req0, 2'b10 locked to req1.
REQ-015 fifo_count  output  FIFO_BITS+1  current FIFO occupancy.

Function
REQ-016 States: IDLE, LOCK0, LOCK1; a transfer is reqN_valid && reqN_ready at a rising edge.
REQ-017 IDLE: grant goes to the sole valid requester; both valid -> the requester not equal to last_grant wins.
REQ-018 LOCKn: only requester n is granted; the other requester's ready is held low.
REQ-019 reqN_ready = granted(N) && !fifo_full; push is blocked when full even if a pop occurs the same cycle.
REQ-020 Transfer of a non-newline character from N: state -> LOCKN, last_grant <= N, timeout counter cleared.
REQ-021 Transfer of 7'h0A from N: state -> IDLE, last_grant <= N.
REQ-022 Transfer of any character, including 7'h08, in LOCKN: stays LOCKN and clears the timeout counter.
REQ-023 In LOCKN with no transfer: counter increments; on reaching LOCK_TIMEOUT: state -> IDLE, counter cleared.
REQ-024 Accepted characters are pushed into the FIFO in acceptance order, at most one push per cycle.
REQ-025 Pop occurs when FIFO is non-empty and gap counter is 0; pop registers add_char=1 and char_value=head on the next edge.
REQ-026 add_char is high for exactly one cycle per pop; it is low otherwise, and char_value holds its last value.
REQ-027 After each pop the gap counter loads GAP_CYCLES and decrements to 0; GAP_CYCLES=0 allows a pop every cycle.
REQ-028 Latency with an empty FIFO and gap 0: a character accepted at edge N has add_char high during the cycle after edge N+1.
REQ-029 Simultaneous push and pop: occupancy unchanged, and both operations take effect.
REQ-030 Pointers wrap modulo FIFO_DEPTH.
REQ-031 fifo_count saturates at FIFO_DEPTH only through REQ-019 blocking; it is never exceeded.
REQ-032 owner reflects state combinationally.

Reset
REQ-033 While reset is high, outputs are forced: add_char=0, char_value=0, owner=0, fifo_count=0, req0_ready and req1_ready low.
REQ-034 Reset values: state=IDLE, last_grant=1 (req0 wins first tie), timeout and gap counters=0, FIFO pointers=0.
REQ-035 Reset asserted mid-line or mid-drain discards FIFO contents and releases any lock; no add_char follows the reset.

Structure
REQ-036 Shared package term_pkg holds CHAR_NEWLINE=7'h0A, CHAR_BACKSPACE=7'h08, and the arbiter state encoding.
REQ-037 FIFO is one sub-module, term_char_fifo (synchronous write/read, full/empty/count), with asynchronous reset.
REQ-038 Target size: 120-400 lines of RTL total.

Verification
REQ-039 Tie: both valid from reset with chars 'A'(7'h41) and 'B'(7'h42) -> req0 granted; add_char outputs 'A' first, and req1 stays blocked until req0 sends 7'h0A.
REQ-040 Line atomicity: req0 sends "HI\n" while req1 continuously valid with 'X' -> output 7'h48,7'h49,7'h0A,7'h58.
REQ-041 Timeout: req0 sends 'Q' then stays idle, req1 valid -> req1 granted exactly LOCK_TIMEOUT idle cycles after the last req0 transfer.
REQ-042 Full: GAP_CYCLES=3, req0 streams 20 chars -> ready drops when fifo_count=16; pulses are spaced by 4 cycles; no loss or reorder.
REQ-043 Reset mid-drain: reset asserted with fifo_count=5 -> fifo_count=0, owner=0, and no add_char after reset.
REQ-044 Alternation: both requesters send single 7'h0A repeatedly -> grants alternate 0,1,0,1.
